// File: rtl/mpr121_i2c_target.sv
// MPR121-compatible I2C target: 7-bit address match, auto-incrementing register
// pointer, writable register file, and live touch status snapshotted at 0x00/0x01.
module mpr121_i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h5A,
  parameter int unsigned REG_DEPTH   = 128,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe_out,
  input  logic [11:0] touch_status_in,
  output logic        wr_valid_out,
  output logic [7:0]  wr_addr_out,
  output logic [7:0]  wr_data_out,
  output logic        busy_out
);
  localparam int unsigned PW = $clog2(REG_DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  state_t                 state_q, state_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]          ptr_q, ptr_d, ptr_next;
  logic [11:0]            snap_q, snap_d;
  logic                   oe_q, oe_d, busy_q, busy_d, wr_valid_q, wr_valid_d;
  logic [7:0]             wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic                   reg_we;
  logic [7:0]             regs_q [REG_DEPTH];
  logic [7:0]             rd_byte;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, bit_full, rx_done;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high in both samples, so a coincident SCL/SDA change stays a data edge
  assign start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
  assign stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
  assign bit_full  = (bit_cnt_q == 4'd8);
  assign rx_done   = scl_fall & bit_full;
  assign ptr_next  = (ptr_q == PW'(REG_DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    if (ptr_q == PW'(0))      rd_byte = snap_q[7:0];
    else if (ptr_q == PW'(1)) rd_byte = {4'b0, snap_q[11:8]};
    else                      rd_byte = regs_q[ptr_q];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      ptr_q      <= '0;
      snap_q     <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      scl_sync_q <= SYNC_STAGES'({scl_sync_q, scl_in});
      sda_sync_q <= SYNC_STAGES'({sda_sync_q, sda_in});
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      ptr_q      <= ptr_d;
      snap_q     <= snap_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[ptr_q] <= shreg_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det)     state_d = ADDR;
    else if (stop_det) state_d = IDLE;
    else begin
      case (state_q)
        ADDR:     if (rx_done) state_d = (shreg_q[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall) state_d = shreg_q[0] ? RD_DATA : PTR;
        PTR:      if (rx_done) state_d = PTR_ACK;
        PTR_ACK:  if (scl_fall) state_d = WR_DATA;
        WR_DATA:  if (rx_done) state_d = WR_ACK;
        WR_ACK:   if (scl_fall) state_d = WR_DATA;
        RD_DATA:  if (rx_done) state_d = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_s) state_d = IGNORE;
          else if (scl_fall)     state_d = RD_DATA;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    ptr_d      = ptr_q;
    snap_d     = snap_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;
    if (start_det) begin
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      oe_d   = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_DATA: begin
          if (scl_rise && !bit_full) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (rx_done) begin
            bit_cnt_d = '0;
            if (state_q == ADDR) begin
              if (shreg_q[7:1] == TARGET_ADDR) begin
                oe_d   = 1'b1;
                busy_d = 1'b1;
                if (shreg_q[0]) snap_d = touch_status_in;
              end
            end else if (state_q == PTR) begin
              oe_d  = 1'b1;
              ptr_d = PW'({1'b0, shreg_q} % 9'(REG_DEPTH));
            end else begin
              // 0x00/0x01 are read-only but the byte is still ACKed and reported
              oe_d       = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = 8'(ptr_q);
              wr_data_d  = shreg_q;
              reg_we     = (ptr_q > PW'(1));
              ptr_d      = ptr_next;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            oe_d      = 1'b0;
            bit_cnt_d = '0;
            if (shreg_q[0]) begin
              shreg_d = rd_byte;
              oe_d    = ~rd_byte[7];
            end
          end
        end
        PTR_ACK, WR_ACK: if (scl_fall) oe_d = 1'b0;
        RD_DATA: begin
          if (scl_rise && !bit_full) bit_cnt_d = bit_cnt_q + 4'd1;
          else if (rx_done) begin
            oe_d      = 1'b0;
            bit_cnt_d = '0;
          end else if (scl_fall) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            oe_d    = ~shreg_q[6];
          end
        end
        RD_ACK: begin
          if (scl_rise && !sda_s) ptr_d = ptr_next;
          else if (scl_fall) begin
            shreg_d = rd_byte;
            oe_d    = ~rd_byte[7];
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  assign sda_oe_out   = oe_q;
  assign busy_out     = busy_q;
  assign wr_valid_out = wr_valid_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;
endmodule

// File: tb/tb_mpr121_i2c_target.sv
// Bench for mpr121_i2c_target: bus-level controller driving randomized
// transactions, a register-map reference model, and queue-based scoreboards.
module tb_mpr121_i2c_target;
  localparam int Q = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [11:0] touch = '0;
  logic        sda_oe, wr_valid, busy;
  logic [7:0]  wr_addr, wr_data;
  logic        sda_line;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  mpr121_i2c_target #(.TARGET_ADDR(7'h5A), .REG_DEPTH(128), .SYNC_STAGES(2)) dut (
    .clk_in(clk), .rst_in(rst_n), .scl_in(scl), .sda_in(sda_line),
    .sda_oe_out(sda_oe), .touch_status_in(touch), .wr_valid_out(wr_valid),
    .wr_addr_out(wr_addr), .wr_data_out(wr_data), .busy_out(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_rd[$], obs_rd[$];
  logic        exp_ack[$], obs_ack[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  wbuf[$];

  logic [7:0]  mregs [128];
  int          mptr = 0;
  logic [11:0] msnap = '0;

  int   viol = 0;
  logic oe_prev = 1'b0;
  logic oe_seen = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endfunction

  function automatic logic [7:0] model_rd(input int p);
    if (p == 0) return msnap[7:0];
    if (p == 1) return {4'h0, msnap[11:8]};
    return mregs[p];
  endfunction

  always @(negedge clk) begin
    if (wr_valid) begin
      if (exp_wr.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
      end else chk("wr_pulse", {wr_addr, wr_data}, exp_wr.pop_front());
    end
    while (obs_ack.size() > 0) begin
      if (exp_ack.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ack_unexpected: got %0b expected nothing", obs_ack.pop_front());
      end else chk("ack", obs_ack.pop_front(), exp_ack.pop_front());
    end
    while (obs_rd.size() > 0) begin
      if (exp_rd.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h expected nothing", obs_rd.pop_front());
      end else chk("rd_byte", obs_rd.pop_front(), exp_rd.pop_front());
    end
    if (sda_oe === 1'b1) oe_seen = 1'b1;
    if (rst_n && sda_oe !== oe_prev && scl) viol++;
    oe_prev = sda_oe;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clks(Q);
    scl = 1'b1;   wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl = 1'b0;   wait_clks(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl = 1'b1;   wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b; wait_clks(Q);
    scl = 1'b1; wait_clks(Q / 2);
    s = sda_line; wait_clks(Q - Q / 2);
    scl = 1'b0; wait_clks(2);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack_exp);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    exp_ack.push_back(ack_exp);
    bus_bit(1'b1, s);
    obs_ack.push_back(s);
  endtask

  task automatic recv_byte(input logic nack, input logic [7:0] expv);
    logic [7:0] d;
    logic s;
    exp_rd.push_back(expv);
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    obs_rd.push_back(d);
    bus_bit(nack, s);
  endtask

  // Write pointer p then every byte queued in wbuf.
  task automatic do_write(input logic [7:0] p, input bit stop);
    bus_start();
    send_byte({7'h5A, 1'b0}, 1'b0);
    send_byte(p, 1'b0);
    mptr = int'(p) % 128;
    foreach (wbuf[k]) begin
      exp_wr.push_back({8'(mptr), wbuf[k]});
      send_byte(wbuf[k], 1'b0);
      if (mptr > 1) mregs[mptr] = wbuf[k];
      mptr = (mptr + 1) % 128;
    end
    wbuf.delete();
    if (stop) bus_stop();
  endtask

  task automatic do_read(input int n, input bit chg_touch);
    bus_start();
    send_byte({7'h5A, 1'b1}, 1'b0);
    msnap = touch;
    if (chg_touch) touch = ~touch;
    chk("busy_in_read", busy, 1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, model_rd(mptr));
      if (k < n - 1) mptr = (mptr + 1) % 128;
    end
    bus_stop();
  endtask

  task automatic do_foreign(input logic [6:0] a, input logic rw);
    oe_seen = 1'b0;
    bus_start();
    send_byte({a, rw}, 1'b1);
    chk("foreign_busy", busy, 0);
    bus_stop();
    chk("foreign_sda_driven", oe_seen, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] fa;
    logic       s;
    int         len;
    for (int i = 0; i < 128; i++) mregs[i] = '0;
    wait_clks(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_bus", {wr_addr, wr_data}, 0);
    rst_n = 1'b1;
    wait_clks(5);

    wbuf = {8'h8F};
    do_write(8'h5E, 1);
    chk("idle_after_stop_busy", busy, 0);
    do_write(8'h5E, 0);
    do_read(1, 0);

    touch = 12'hA53;
    do_write(8'h00, 0);
    do_read(2, 1);

    do_foreign(7'h5B, 1'b0);

    wbuf = {8'h11, 8'h99};
    do_write(8'h7F, 1);
    touch = 12'($urandom);
    do_write(8'h7E, 0);
    do_read(3, 0);

    wbuf = {8'h3C};
    do_write(8'h5E, 1);
    do_write(8'h5E, 0);
    bus_start();
    send_byte({7'h5A, 1'b1}, 1'b0);
    wait_clks(3);
    chk("rd_zero_bit_driven", sda_oe, 1);
    rst_n = 1'b0;
    wait_clks(1);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    wait_clks(3);
    rst_n = 1'b1;
    for (int i = 0; i < 128; i++) mregs[i] = '0;
    mptr = 0;
    msnap = '0;
    bus_stop();
    do_write(8'h5E, 0);
    do_read(1, 0);

    do_write(8'h20, 0);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
    bus_stop();
    chk("abort_busy", busy, 0);
    wbuf = {8'hC7};
    do_write(8'h21, 0);
    do_write(8'h20, 0);
    do_read(2, 0);

    for (int t = 0; t < 20; t++) begin
      len = int'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0: begin
          for (int k = 0; k < len; k++) wbuf.push_back(8'($urandom));
          do_write(8'($urandom), 1);
        end
        1: begin
          touch = 12'($urandom);
          do_write(8'($urandom), 0);
          do_read(len, 0);
        end
        2: begin
          fa = 7'($urandom);
          if (fa == 7'h5A) fa = 7'h5B;
          do_foreign(fa, 1'($urandom));
        end
        default: begin
          touch = 12'($urandom);
          do_read(len, 0);
        end
      endcase
    end

    wait_clks(10);
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_ack_drained", exp_ack.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    chk("oe_change_while_scl_high", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
